// File: rtl/wb_bus_monitor.sv
// rtl/wb_bus_monitor.sv - passive Wishbone classic activity monitor with stretched LEDs,
// saturating counters and a stall-timeout detector.
module wb_bus_monitor #(
   parameter int LEDS    = 8,
   parameter int DW      = 32,
   parameter int CNT_W   = 16,
   parameter int STRETCH = 1000000,
   parameter int TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wb_stb,
   input  logic             wb_we,
   input  logic [DW-1:0]    wb_dat_c,
   input  logic             wb_ack,
   input  logic [DW-1:0]    wb_dat_p,
   input  logic [1:0]       mode,
   input  logic             clr,
   output logic [LEDS-1:0]  led,
   output logic [CNT_W-1:0] rd_cnt,
   output logic [CNT_W-1:0] wr_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic             err
);

   localparam int SW = $clog2(STRETCH + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [SW-1:0] STR_LOAD = SW'(STRETCH);
   localparam logic [TW-1:0] TMO_M1   = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      STALL = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [TW-1:0]   stall_cnt;
   logic [SW-1:0]   rd_str;
   logic [SW-1:0]   wr_str;
   logic [DW-1:0]   last_dat;

   logic            comp;
   logic            rd_comp;
   logic            wr_comp;
   logic            timeout_ev;
   logic            rd_ind;
   logic            wr_ind;
   logic            busy;

   logic [LEDS-1:0] rd_l;
   logic [LEDS-1:0] wr_l;
   logic [LEDS-1:0] dat_l;
   logic [LEDS-1:0] sum_l;
   logic [LEDS+3:0] m0_v;
   logic [LEDS-1:0] led_nx;
   logic            unused_bits;

   // A completion is any strobed, acknowledged cycle regardless of FSM state,
   // so late acks from STALL are counted like any other.
   assign comp       = wb_stb && wb_ack;
   assign rd_comp    = comp && !wb_we;
   assign wr_comp    = comp && wb_we;
   assign timeout_ev = (state == WAIT) && wb_stb && !wb_ack && (stall_cnt == TMO_M1);
   assign rd_ind     = (rd_str != '0);
   assign wr_ind     = (wr_str != '0);
   assign busy       = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (wb_stb && !wb_ack) begin
               state_nx = WAIT;
            end
         end
         WAIT: begin
            if (!wb_stb || wb_ack) begin
               state_nx = IDLE;
            end else if (stall_cnt == TMO_M1) begin
               state_nx = STALL;
            end
         end
         STALL: begin
            if (!wb_stb || wb_ack) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Stall counter counts cycles spent waiting; it freezes once STALL is reached.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (state == IDLE) begin
         stall_cnt <= (wb_stb && !wb_ack) ? TW'(1) : '0;
      end else if (state == WAIT && wb_stb && !wb_ack) begin
         stall_cnt <= stall_cnt + TW'(1);
      end else if (state_nx == IDLE) begin
         stall_cnt <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         rd_cnt  <= '0;
         wr_cnt  <= '0;
         err_cnt <= '0;
         err     <= 1'b0;
      end else begin
         if (rd_comp && rd_cnt != '1) begin
            rd_cnt <= rd_cnt + CNT_W'(1);
         end
         if (wr_comp && wr_cnt != '1) begin
            wr_cnt <= wr_cnt + CNT_W'(1);
         end
         if (timeout_ev) begin
            err <= 1'b1;
            if (err_cnt != '1) begin
               err_cnt <= err_cnt + CNT_W'(1);
            end
         end
      end
   end

   // Stretchers and last-data ignore clr so the activity display stays honest.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_str <= '0;
      end else if (rd_comp) begin
         rd_str <= STR_LOAD;
      end else if (rd_str != '0) begin
         rd_str <= rd_str - SW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_str <= '0;
      end else if (wr_comp) begin
         wr_str <= STR_LOAD;
      end else if (wr_str != '0) begin
         wr_str <= wr_str - SW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_dat <= '0;
      end else if (rd_comp) begin
         last_dat <= wb_dat_p;
      end else if (wr_comp) begin
         last_dat <= wb_dat_c;
      end
   end

   // Fit each display source to LEDS bits: truncate when wider, zero-extend when narrower.
   if (CNT_W >= LEDS) begin : g_cnt_trunc
      assign rd_l = rd_cnt[LEDS-1:0];
      assign wr_l = wr_cnt[LEDS-1:0];
   end else begin : g_cnt_ext
      assign rd_l = {{(LEDS-CNT_W){1'b0}}, rd_cnt};
      assign wr_l = {{(LEDS-CNT_W){1'b0}}, wr_cnt};
   end

   if (DW >= LEDS) begin : g_dat_trunc
      assign dat_l = last_dat[LEDS-1:0];
   end else begin : g_dat_ext
      assign dat_l = {{(LEDS-DW){1'b0}}, last_dat};
   end

   assign sum_l       = rd_l + wr_l;
   assign m0_v        = {sum_l, err, busy, wr_ind, rd_ind};
   assign unused_bits = ^{last_dat, m0_v};

   always_comb begin
      led_nx = '0;
      case (mode)
         2'd0:    led_nx = m0_v[LEDS-1:0];
         2'd1:    led_nx = rd_l;
         2'd2:    led_nx = wr_l;
         default: led_nx = dat_l;
      endcase
   end

   // All-ones during reset doubles as a lamp test.
   always_ff @(posedge clk) begin
      if (rst) begin
         led <= '1;
      end else begin
         led <= led_nx;
      end
   end

endmodule

// File: tb/tb_wb_bus_monitor.sv
// tb/tb_wb_bus_monitor.sv - scoreboard bench for wb_bus_monitor.
module tb_wb_bus_monitor;

   localparam int LEDS    = 8;
   localparam int DW      = 32;
   localparam int CNT_W   = 4;
   localparam int STRETCH = 4;
   localparam int TIMEOUT = 8;

   localparam int SIG_LED = 0;
   localparam int SIG_RD  = 1;
   localparam int SIG_WR  = 2;
   localparam int SIG_EC  = 3;
   localparam int SIG_ERR = 4;
   localparam logic [31:0] FULL = 32'hFFFF_FFFF;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             wb_stb = 1'b0;
   logic             wb_we = 1'b0;
   logic             wb_ack = 1'b0;
   logic             clr = 1'b0;
   logic [DW-1:0]    wb_dat_c = '0;
   logic [DW-1:0]    wb_dat_p = '0;
   logic [1:0]       mode = 2'd0;
   logic [LEDS-1:0]  led;
   logic [CNT_W-1:0] rd_cnt;
   logic [CNT_W-1:0] wr_cnt;
   logic [CNT_W-1:0] err_cnt;
   logic             err;

   wb_bus_monitor #(
      .LEDS(LEDS), .DW(DW), .CNT_W(CNT_W), .STRETCH(STRETCH), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .wb_stb(wb_stb), .wb_we(wb_we), .wb_dat_c(wb_dat_c),
      .wb_ack(wb_ack), .wb_dat_p(wb_dat_p), .mode(mode), .clr(clr), .led(led),
      .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .err_cnt(err_cnt), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          at;
      int          sig;
      logic [31:0] mask;
      logic [31:0] value;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   task automatic sb_push(input int rel, input int sig, input logic [31:0] mask,
                          input logic [31:0] value, input string name);
      exp_t e;
      e.at    = cyc + rel;
      e.sig   = sig;
      e.mask  = mask;
      e.value = value;
      e.name  = name;
      sb.push_back(e);
   endtask

   function automatic logic [31:0] probe(input int sig);
      case (sig)
         SIG_LED: return 32'(led);
         SIG_RD:  return 32'(rd_cnt);
         SIG_WR:  return 32'(wr_cnt);
         SIG_EC:  return 32'(err_cnt);
         default: return 32'(err);
      endcase
   endfunction

   always @(negedge clk) begin
      logic [31:0] act;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].at <= cyc) begin
            act = probe(sb[i].sig) & sb[i].mask;
            checks++;
            if (sb[i].at < cyc || act != (sb[i].value & sb[i].mask)) begin
               failures++;
               $display("FAIL %s cyc=%0d got=%h want=%h", sb[i].name, cyc, act,
                        sb[i].value & sb[i].mask);
            end
            sb.delete(i);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input logic stb, input logic we, input logic ack);
      wb_stb = stb;
      wb_we  = we;
      wb_ack = ack;
   endtask

   initial begin
      int guard;
      step(3);
      sb_push(0, SIG_LED, FULL, 32'hFF, "reset_led");
      sb_push(0, SIG_RD,  FULL, 0, "reset_rd");
      sb_push(0, SIG_WR,  FULL, 0, "reset_wr");
      sb_push(0, SIG_EC,  FULL, 0, "reset_ec");
      sb_push(0, SIG_ERR, FULL, 0, "reset_err");
      rst = 1'b0;
      sb_push(1, SIG_LED, FULL, 32'h00, "led_after_reset");
      step(1);

      // single read
      wb_dat_p = 32'h33;
      sb_push(1, SIG_RD, FULL, 1, "rd_single");
      sb_push(1, SIG_WR, FULL, 0, "wr_untouched");
      for (int r = 2; r <= 5; r++) sb_push(r, SIG_LED, FULL, 32'h11, "rd_led_lit");
      sb_push(6, SIG_LED, FULL, 32'h10, "rd_led_off");
      drive(1, 0, 1); step(1); drive(0, 0, 0); step(6);

      // write retrigger
      wb_dat_c = 32'h11;
      sb_push(1, SIG_WR, FULL, 1, "wr_first");
      sb_push(3, SIG_WR, FULL, 2, "wr_second");
      for (int r = 2; r <= 7; r++) sb_push(r, SIG_LED, 32'h02, 32'h02, "wr_led_stretch");
      sb_push(8, SIG_LED, 32'h02, 0, "wr_led_off");
      sb_push(4, SIG_LED, 32'hF0, 32'h30, "led_sum");
      drive(1, 1, 1); step(1); drive(0, 0, 0); step(1);
      drive(1, 1, 1); step(1); drive(0, 0, 0); step(7);

      // timeout then late ack
      sb_push(2,  SIG_LED, 32'h04, 32'h04, "busy_led");
      sb_push(7,  SIG_ERR, FULL, 0, "err_before_timeout");
      sb_push(8,  SIG_ERR, FULL, 1, "err_at_timeout");
      sb_push(8,  SIG_EC,  FULL, 1, "ec_first");
      sb_push(9,  SIG_LED, 32'h08, 32'h08, "err_led");
      sb_push(12, SIG_RD,  FULL, 2, "late_ack_counted");
      sb_push(12, SIG_ERR, FULL, 1, "err_sticky");
      sb_push(12, SIG_EC,  FULL, 1, "ec_once");
      sb_push(13, SIG_LED, 32'h04, 0, "idle_after_ack");
      drive(1, 0, 0); step(11); drive(1, 0, 1); step(1); drive(0, 0, 0); step(2);

      // second stall, abandoned from STALL
      sb_push(7,  SIG_EC,  FULL, 1, "ec_hold");
      sb_push(8,  SIG_EC,  FULL, 2, "ec_second");
      sb_push(10, SIG_LED, 32'h04, 0, "idle_after_drop");
      sb_push(10, SIG_RD,  FULL, 2, "drop_uncounted");
      drive(1, 0, 0); step(8); drive(0, 0, 0); step(3);

      // clear, then abandoned transfer
      clr = 1'b1;
      sb_push(1, SIG_RD,  FULL, 0, "clr_rd");
      sb_push(1, SIG_WR,  FULL, 0, "clr_wr");
      sb_push(1, SIG_EC,  FULL, 0, "clr_ec");
      sb_push(1, SIG_ERR, FULL, 0, "clr_err");
      step(1); clr = 1'b0;
      sb_push(3, SIG_LED, 32'h04, 32'h04, "abandon_busy");
      sb_push(4, SIG_RD,  FULL, 0, "abandon_rd");
      sb_push(4, SIG_ERR, FULL, 0, "abandon_err");
      sb_push(4, SIG_EC,  FULL, 0, "abandon_ec");
      sb_push(5, SIG_LED, 32'h04, 0, "abandon_idle");
      sb_push(5, SIG_LED, 32'h08, 0, "err_led_cleared");
      drive(1, 0, 0); step(3); drive(0, 0, 0); step(3);

      // clr coincident with a write
      wb_dat_p = 32'h44;
      sb_push(1, SIG_RD, FULL, 1, "pre_clr_read");
      drive(1, 0, 1); step(1); drive(0, 0, 0); step(1);
      clr = 1'b1; wb_dat_c = 32'h5A;
      sb_push(1, SIG_RD,  FULL, 0, "clr_wins_rd");
      sb_push(1, SIG_WR,  FULL, 0, "clr_wins_wr");
      sb_push(1, SIG_EC,  FULL, 0, "clr_wins_ec");
      sb_push(1, SIG_ERR, FULL, 0, "clr_wins_err");
      sb_push(2, SIG_LED, 32'h02, 32'h02, "clr_wr_led");
      drive(1, 1, 1); step(1); clr = 1'b0; drive(0, 0, 0); step(5);
      mode = 2'd3;
      sb_push(1, SIG_LED, FULL, 32'h5A, "mode3_clr_data");
      step(1); mode = 2'd0; step(1);

      // saturation and display modes
      wb_dat_p = 32'h77;
      sb_push(14, SIG_RD, FULL, 14, "rd_count14");
      sb_push(15, SIG_RD, FULL, 15, "rd_sat");
      sb_push(20, SIG_RD, FULL, 15, "rd_sat_hold");
      drive(1, 0, 1); step(20); drive(0, 0, 0);
      mode = 2'd1;
      sb_push(1, SIG_LED, FULL, 32'h0F, "mode1_rd");
      step(1);
      wb_dat_c = 32'hA5;
      sb_push(1, SIG_WR, FULL, 1, "wr_after_sat");
      drive(1, 1, 1); step(1); drive(0, 0, 0);
      mode = 2'd3;
      sb_push(1, SIG_LED, FULL, 32'hA5, "mode3_data");
      step(1);
      mode = 2'd2;
      sb_push(1, SIG_LED, FULL, 32'h01, "mode2_wr");
      step(1);

      // reset with stb held, then fresh start from IDLE
      drive(1, 0, 0); rst = 1'b1;
      sb_push(1, SIG_LED, FULL, 32'hFF, "rst_led");
      sb_push(1, SIG_RD,  FULL, 0, "rst_rd");
      sb_push(1, SIG_WR,  FULL, 0, "rst_wr");
      sb_push(1, SIG_EC,  FULL, 0, "rst_ec");
      sb_push(1, SIG_ERR, FULL, 0, "rst_err");
      step(2); rst = 1'b0;
      sb_push(1, SIG_LED, FULL, 32'h00, "post_rst_led");
      sb_push(7, SIG_ERR, FULL, 0, "fresh_start_no_err");
      sb_push(8, SIG_ERR, FULL, 1, "fresh_start_timeout");
      sb_push(8, SIG_EC,  FULL, 1, "fresh_start_ec");
      step(8); drive(0, 0, 0); step(2);

      guard = 0;
      while (sb.size() != 0 && guard < 50) begin
         step(1);
         guard++;
      end
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_bus_monitor.md
Name: wb_bus_monitor

Overview:
- Parametrised Wishbone classic bus activity monitor driving a debug LED bank.
- Successor to the 8-LED blinker: adds configurable LED, data and counter widths, pulse-stretched read/write indicators, and saturating read/write/error counters.
- Adds a stall-timeout detector with a sticky error flag, plus a selectable display mode.
- Passive tap: sits beside the controller/peripheral pair, never drives the bus.

Parameters:
- LEDS, 8: LED output width; must be >= 4.
- DW, 32: Wishbone data width.
- CNT_W, 16: width of rd/wr/err counters.
- STRETCH, 1000000: cycles an activity LED stays lit after a completion; >= 1.
- TIMEOUT, 1024: stall cycles (stb high, ack low) before a timeout is declared; >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- wb_stb  in  1  controller strobe (cyc folded in).
- wb_we  in  1  controller write enable.
- wb_dat_c  in  DW  controller write data.
- wb_ack  in  1  peripheral acknowledge.
- wb_dat_p  in  DW  peripheral read data.
- mode  in  2  display select.
- clr  in  1  synchronous clear of counters and error flag.
- led  out  LEDS  registered LED drive.
- rd_cnt  out  CNT_W  completed reads.
- wr_cnt  out  CNT_W  completed writes.
- err_cnt  out  CNT_W  timeouts seen.
- err  out  1  sticky timeout flag.

Behaviour:
- Completion: any cycle with wb_stb && wb_ack. Read if !wb_we, write if wb_we. Back-to-back completions on consecutive cycles each count.
- Counters:
  - rd_cnt/wr_cnt increment on the cycle after a completion.
  - All counters saturate at 2^CNT_W-1; no wrap.
- Last data: on completion, a DW register captures wb_dat_p (read) or wb_dat_c (write).
- FSM, states IDLE, WAIT, STALL:
  - IDLE: stb && !ack -> WAIT, stall counter = 1. stb && ack -> stays IDLE (single-cycle completion). !stb -> stays IDLE.
  - WAIT: ack -> IDLE. !stb -> IDLE (abandoned, not counted). Otherwise stall counter +1. When it reaches TIMEOUT -> STALL, err <= 1, err_cnt +1 (once per stall).
  - STALL: stall counter holds. A late ack still counts as a completion and returns to IDLE. !stb -> IDLE. err stays set.
- Stretchers (one each for read and write):
  - Counter loaded with STRETCH on that completion type; decrements to 0.
  - Indicator = counter != 0, so it is lit from the cycle after the completion for exactly STRETCH cycles.
  - A retrigger reloads to STRETCH.
- led, registered, one-cycle latency from its sources:
  - mode 0: led[0]=rd indicator, led[1]=wr indicator, led[2]=(state!=IDLE), led[3]=err, led[LEDS-1:4]=low bits of (rd_cnt+wr_cnt).
  - mode 1: rd_cnt low LEDS bits.
  - mode 2: wr_cnt low LEDS bits.
  - mode 3: last-data low LEDS bits.
  - Any source narrower than LEDS is zero-extended.
  - A mode change takes effect on the next led update.
- clr:
  - Zeros rd_cnt, wr_cnt, err_cnt and err.
  - A same-cycle completion or timeout is discarded: clr wins.
  - Stretchers, FSM and last-data are unaffected.
- Reset:
  - Counters, err, stretchers and last-data clear to 0; FSM goes to IDLE.
  - led resets to all ones (lamp test) and shows normal display from the first clock after rst deasserts.
  - Reset mid-transaction abandons it, uncounted.
  - After reset, if stb is still high, the next cycle is treated as a fresh start from IDLE.

Test Plan:
- STRETCH=4, TIMEOUT=8, mode 0. Single read (stb=1, we=0, ack same cycle) -> rd_cnt=1 next cycle. led[0] is 1 for cycles +1..+4 (visible one cycle later on led), then 0. wr_cnt=0.
- Retrigger: writes at t=0 and t=2 -> wr indicator continuously high t+1..t+6, wr_cnt=2, led[7:4]=2.
- Timeout: stb=1, no ack for 8 cycles -> err=1, err_cnt=1, state STALL. Ack at cycle 12 -> rd_cnt +1, back to IDLE, err still 1. A second stall -> err_cnt=2.
- Abandon: stb high 3 cycles, then low, no ack -> no counts, err=0, IDLE.
- clr coincident with a write completion -> all counters 0, err 0, write not counted. wr indicator still fires, since stretcher and last-data are not affected by clr.
- Saturation and modes: CNT_W=4, drive 20 reads -> rd_cnt=15. Mode 1 -> led=0x0F. Write wb_dat_c=0xA5 then mode 3 -> led=0xA5. Assert rst -> led=0xFF, counters 0.
